// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes
// resolved in MEM, data-memory waits with timeout, and saturating profiling counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_mem_Branch,
  input  logic             ex_mem_Zero,
  input  logic             ex_mem_MemRead,
  input  logic             ex_mem_MemWrite,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       state,
  output logic             error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned      WaitW   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2,
    StError   = 2'd3
  } state_e;

  state_e           r_state;
  state_e           w_next_state;
  logic [WaitW-1:0] r_wait_cnt;
  logic [WaitW-1:0] w_wait_cnt_next;
  logic             r_error;
  logic             w_error_set;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_mem_stall;
  logic w_br_taken;
  logic w_load_use;
  logic w_branch_act;
  logic w_freeze;

  logic w_pc_write;
  logic w_pc_src;
  logic w_if_id_write;
  logic w_id_ex_write;
  logic w_ex_mem_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_ex_mem_flush;

  assign w_mem_stall = (ex_mem_MemRead | ex_mem_MemWrite) & ~mem_ready;
  assign w_br_taken  = ex_mem_Branch & ex_mem_Zero;
  assign w_load_use  = id_ex_MemRead && (id_ex_rd != 5'd0) &&
                       ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  // RUN freezes on a new memory stall; MEM_WAIT keeps freezing until mem_ready.
  assign w_freeze = ((r_state == StRun) && w_mem_stall) ||
                    ((r_state == StMemWait) && !mem_ready);

  always_comb begin
    w_pc_write      = 1'b1;
    w_pc_src        = 1'b0;
    w_if_id_write   = 1'b1;
    w_id_ex_write   = 1'b1;
    w_ex_mem_write  = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_flush  = 1'b0;
    w_next_state    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_error_set     = 1'b0;
    w_branch_act    = 1'b0;

    unique case (r_state)
      StRun, StMemWait: begin
        if (w_freeze) begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_write  = 1'b0;
          w_ex_mem_write = 1'b0;
          if (r_state == StRun) begin
            w_next_state    = StMemWait;
            w_wait_cnt_next = WaitW'(1);
          end else if (r_wait_cnt == WaitMax) begin
            w_next_state = StError;
            w_error_set  = 1'b1;
          end else begin
            w_wait_cnt_next = r_wait_cnt + WaitW'(1);
          end
        end else begin
          w_next_state    = StRun;
          w_wait_cnt_next = '0;
          // Branch wins over load-use: the flush kills the consumer anyway.
          if (w_br_taken) begin
            w_pc_src       = 1'b1;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_branch_act   = 1'b1;
            w_next_state   = StFlush;
          end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
          end
        end
      end
      StFlush: begin
        w_next_state = StRun;
      end
      StError: begin
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_id_ex_write  = 1'b0;
        w_ex_mem_write = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StRun;
      r_wait_cnt  <= '0;
      r_error     <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_error_set) begin
        r_error <= 1'b1;
      end
      if (!w_pc_write && (r_stall_cnt != CntMax)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_branch_act && (r_flush_cnt != CntMax)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_write     = w_pc_write & ~reset;
  assign pc_src       = w_pc_src & ~reset;
  assign if_id_write  = w_if_id_write & ~reset;
  assign id_ex_write  = w_id_ex_write & ~reset;
  assign ex_mem_write = w_ex_mem_write & ~reset;
  assign if_id_flush  = w_if_id_flush & ~reset;
  assign id_ex_flush  = w_id_ex_flush & ~reset;
  assign ex_mem_flush = w_ex_mem_flush & ~reset;
  assign state        = r_state;
  assign error        = r_error;
  assign stall_cycles = r_stall_cnt;
  assign flush_events = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] SAT = '1;

  // Output bundle order: pc_write pc_src if_id_w id_ex_w ex_mem_w if_id_f id_ex_f ex_mem_f
  localparam logic [7:0] O_DEF = 8'b1011_1000;
  localparam logic [7:0] O_FRZ = 8'b0000_0000;
  localparam logic [7:0] O_BR  = 8'b1111_1111;
  localparam logic [7:0] O_LU  = 8'b0001_1010;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic id_ex_MemRead, ex_mem_Branch, ex_mem_Zero, ex_mem_MemRead, ex_mem_MemWrite, mem_ready;
  logic pc_write, pc_src, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] state;
  logic error;
  logic [CW-1:0] stall_cycles, flush_events;

  int errors = 0;
  int checks = 0;

  // Model state: mode 0=RUN 1=MEM_WAIT 2=FLUSH 3=ERROR
  logic [1:0]    m_mode;
  int            m_wait;
  logic          m_err;
  logic [CW-1:0] m_stall, m_flush;

  logic [7:0]  w_outs;
  logic [20:0] w_all;
  assign w_outs = {pc_write, pc_src, if_id_write, id_ex_write, ex_mem_write,
                   if_id_flush, id_ex_flush, ex_mem_flush};
  assign w_all  = {w_outs, state, error, stall_cycles, flush_events};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_MemRead(id_ex_MemRead), .id_ex_rd(id_ex_rd),
    .ex_mem_Branch(ex_mem_Branch), .ex_mem_Zero(ex_mem_Zero),
    .ex_mem_MemRead(ex_mem_MemRead), .ex_mem_MemWrite(ex_mem_MemWrite),
    .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src),
    .if_id_write(if_id_write), .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .state(state), .error(error),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_outs();
    logic ms, bt, lu;
    ms = (ex_mem_MemRead || ex_mem_MemWrite) && !mem_ready;
    bt = ex_mem_Branch && ex_mem_Zero;
    lu = id_ex_MemRead && id_ex_rd != 0 && (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
    if (reset) return O_FRZ;
    case (m_mode)
      2'd0:    return ms ? O_FRZ : bt ? O_BR : lu ? O_LU : O_DEF;
      2'd1:    return !mem_ready ? O_FRZ : bt ? O_BR : lu ? O_LU : O_DEF;
      2'd2:    return O_DEF;
      default: return O_FRZ;
    endcase
  endfunction

  function automatic logic [20:0] model_all();
    return {model_outs(), m_mode, m_err, m_stall, m_flush};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_advance();
    logic [7:0] o;
    o = model_outs();
    if (reset) begin
      model_reset();
      return;
    end
    if (!o[7] && m_stall != SAT) m_stall = m_stall + 1;
    if (o == O_BR && m_flush != SAT) m_flush = m_flush + 1;
    case (m_mode)
      2'd0: begin
        if (o == O_FRZ) begin m_mode = 1; m_wait = 1; end
        else if (o == O_BR) m_mode = 2;
      end
      2'd1: begin
        if (mem_ready) begin m_mode = (o == O_BR) ? 2'd2 : 2'd0; m_wait = 0; end
        else if (m_wait == TO) begin m_mode = 3; m_err = 1; end
        else m_wait = m_wait + 1;
      end
      2'd2: m_mode = 0;
      default: m_mode = 3;
    endcase
  endtask

  task automatic clear_inputs();
    if_id_rs1 = 0; if_id_rs2 = 0; id_ex_rd = 0; id_ex_MemRead = 0;
    ex_mem_Branch = 0; ex_mem_Zero = 0; ex_mem_MemRead = 0; ex_mem_MemWrite = 0;
    mem_ready = 1;
  endtask

  // Advance one clock; returns 1 ns after the edge so inputs can be driven.
  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    model_reset();
    tick();
    reset = 0;
    #2;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    model_reset();
    #2;
    checks++;
    if (w_all !== {O_FRZ, 2'd0, 1'b0, 5'd0, 5'd0}) begin
      errors++; $display("FAIL reset_hold: got %h want %h", w_all, {O_FRZ, 13'd0});
    end
    tick();
    reset = 0;
    #2;
    checks++;
    if (w_all !== {O_DEF, 13'd0}) begin
      errors++; $display("FAIL reset_release: got %h want %h", w_all, {O_DEF, 13'd0});
    end
  endtask

  task automatic test_load_use();
    do_reset();
    id_ex_MemRead = 1; id_ex_rd = 5; if_id_rs1 = 3; if_id_rs2 = 5;
    #2;
    checks++;
    if (w_outs !== O_LU || w_all !== model_all()) begin
      errors++; $display("FAIL load_use_bubble: got %h want %h", w_all, model_all());
    end
    tick();
    id_ex_MemRead = 0;
    #2;
    checks++;
    if (w_outs !== O_DEF || stall_cycles !== 5'd1 || w_all !== model_all()) begin
      errors++; $display("FAIL load_use_after: got %h want %h", w_all, model_all());
    end
  endtask

  task automatic test_x0_load();
    do_reset();
    id_ex_MemRead = 1; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (w_outs !== O_DEF || w_all !== model_all()) begin
        errors++; $display("FAIL x0_load cyc%0d: got %h want %h", i, w_all, model_all());
      end
      tick();
    end
    checks++;
    if (stall_cycles !== 5'd0) begin
      errors++; $display("FAIL x0_load_count: got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_branch();
    do_reset();
    ex_mem_Branch = 1; ex_mem_Zero = 1;
    #2;
    checks++;
    if (w_outs !== O_BR) begin
      errors++; $display("FAIL branch_taken: got %b want %b", w_outs, O_BR);
    end
    tick();
    clear_inputs();
    #2;
    checks++;
    if (state !== 2'd2 || flush_events !== 5'd1 || w_all !== model_all()) begin
      errors++; $display("FAIL branch_flush_state: got %h want %h", w_all, model_all());
    end
    tick();
    ex_mem_Branch = 1; ex_mem_Zero = 0;
    #2;
    checks++;
    if (state !== 2'd0 || w_outs !== O_DEF || w_all !== model_all()) begin
      errors++; $display("FAIL branch_not_taken: got %h want %h", w_all, model_all());
    end
    tick();
    checks++;
    if (flush_events !== 5'd1 || state !== 2'd0) begin
      errors++; $display("FAIL branch_count: got %0d/%0d want 1/0", flush_events, state);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    ex_mem_MemRead = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (w_outs !== O_FRZ || w_all !== model_all()) begin
        errors++; $display("FAIL mem_wait cyc%0d: got %h want %h", i, w_all, model_all());
      end
      tick();
    end
    mem_ready = 1;
    #2;
    checks++;
    if (w_outs !== O_DEF || state !== 2'd1) begin
      errors++; $display("FAIL mem_release: got %h want outs %h state 1", w_all, O_DEF);
    end
    tick();
    ex_mem_MemRead = 0;
    #2;
    checks++;
    if (state !== 2'd0 || stall_cycles !== 5'd3) begin
      errors++; $display("FAIL mem_wait_done: got state %0d stalls %0d want 0/3", state, stall_cycles);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ex_mem_MemWrite = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    checks++;
    if (state !== 2'd1 || error !== 1'b0) begin
      errors++; $display("FAIL timeout_early: got state %0d err %b want 1/0", state, error);
    end
    tick();
    #2;
    checks++;
    if (state !== 2'd3 || error !== 1'b1 || stall_cycles !== 5'd5 || w_outs !== O_FRZ) begin
      errors++; $display("FAIL timeout_error: got %h want %h", w_all, model_all());
    end
    mem_ready = 1; ex_mem_MemWrite = 0;
    tick(); tick();
    #2;
    checks++;
    if (error !== 1'b1 || state !== 2'd3 || w_all !== model_all()) begin
      errors++; $display("FAIL timeout_sticky: got %h want %h", w_all, model_all());
    end
    do_reset();
    checks++;
    if (error !== 1'b0 || state !== 2'd0) begin
      errors++; $display("FAIL timeout_clear: got err %b state %0d want 0/0", error, state);
    end
  endtask

  task automatic test_priority();
    do_reset();
    ex_mem_MemRead = 1; mem_ready = 0;
    id_ex_MemRead = 1; id_ex_rd = 7; if_id_rs1 = 7;
    #2;
    checks++;
    if (w_outs !== O_FRZ) begin
      errors++; $display("FAIL prio_mem_over_lu: got %b want %b", w_outs, O_FRZ);
    end
    tick(); tick();
    reset = 1;
    model_reset();
    #1;
    checks++;
    if (w_all !== {O_FRZ, 13'd0}) begin
      errors++; $display("FAIL prio_async_reset: got %h want %h", w_all, {O_FRZ, 13'd0});
    end
    tick();
    reset = 0;
    clear_inputs();
    id_ex_MemRead = 1; id_ex_rd = 9; if_id_rs2 = 9;
    ex_mem_Branch = 1; ex_mem_Zero = 1;
    #2;
    checks++;
    if (w_outs !== O_BR || w_all !== model_all()) begin
      errors++; $display("FAIL prio_br_over_lu: got %h want %h", w_all, model_all());
    end
    tick();
    ex_mem_Branch = 0;
    #2;
    checks++;
    if (w_outs !== O_DEF || state !== 2'd2) begin
      errors++; $display("FAIL flush_suppresses_lu: got %h want %h", w_all, model_all());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      ex_mem_Branch = 1; ex_mem_Zero = 1;
      tick();
      clear_inputs();
      tick();
    end
    #2;
    checks++;
    if (flush_events !== SAT || w_all !== model_all()) begin
      errors++; $display("FAIL flush_saturate: got %h want %h", w_all, model_all());
    end
    ex_mem_MemRead = 1; mem_ready = 0;
    for (int i = 0; i < 40; i++) tick();
    #2;
    checks++;
    if (stall_cycles !== SAT || state !== 2'd3 || w_all !== model_all()) begin
      errors++; $display("FAIL stall_saturate: got %h want %h", w_all, model_all());
    end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 60) == 0);
      if (reset) model_reset();
      if_id_rs1       = 5'($urandom_range(0, 3));
      if_id_rs2       = 5'($urandom_range(0, 3));
      id_ex_rd        = 5'($urandom_range(0, 3));
      id_ex_MemRead   = ($urandom_range(0, 2) == 0);
      ex_mem_Branch   = ($urandom_range(0, 4) == 0);
      ex_mem_Zero     = $urandom_range(0, 1) == 1;
      ex_mem_MemRead  = ($urandom_range(0, 4) == 0);
      ex_mem_MemWrite = ($urandom_range(0, 6) == 0);
      mem_ready       = ($urandom_range(0, 3) != 0);
      #2;
      checks++;
      if (w_all !== model_all()) begin
        errors++;
        if (bad < 10) $display("FAIL random cyc%0d: got %h want %h", i, w_all, model_all());
        bad++;
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    model_reset();
    #1;
    test_reset();
    test_load_use();
    test_x0_load();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_priority();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
